bit_serializer: RTL and testbench

Upstream stage for the serial sequence detector. Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock, LSB first, on a single-bit stream. Out drives the detector's In directly. OutValid qualifies each bit. Done marks the last bit of a frame.

---
 rtl/serializer_pkg.sv | 16 +
 rtl/ser_bit_counter.sv | 35 +++
 rtl/bit_serializer.sv | 74 +++++++
 tb/tb_bit_serializer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Optional parity frame bit: SERIALIZER_PARITY_EN (see bit_serializer).
package serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH = 16;

   function automatic int frame_len(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter with zero flag; holds at zero.
// Tracks bits remaining in the current serializer frame.
module ser_bit_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial LSB-first shifter with valid/ready load handshake.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
   import serializer_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Data,
   input  logic             Load,
   output logic             Ready,
   output logic             Out,
   output logic             OutValid,
   output logic             Done
);

`ifdef SERIALIZER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam int FRAME = frame_len(WIDTH, PAR_EN);

   state_e           state_q;
   logic [FRAME-1:0] shreg_q;
   logic [FRAME-1:0] load_word;
   logic             accept;
   logic             cnt_zero;
   logic             shifting;

`ifdef SERIALIZER_PARITY_EN
   assign load_word = {^Data, Data};
`else
   assign load_word = Data;
`endif

   assign shifting = (state_q == SHIFT);
   assign Done     = shifting && cnt_zero;
   assign Ready    = (state_q == IDLE) || Done;
   assign accept   = Load && Ready;
   assign OutValid = shifting;
   assign Out      = shifting && shreg_q[0];

   // A load in the Done cycle restarts the frame with no idle gap.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
      end else if (accept) begin
         state_q <= SHIFT;
         shreg_q <= load_word;
      end else if (shifting) begin
         shreg_q <= shreg_q >> 1;
         if (cnt_zero) begin
            state_q <= IDLE;
         end
      end
   end

   ser_bit_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk_i      (Clk),
      .rst_ni     (Rst),
      .load_i     (accept),
      .load_val_i (CNT_W'(FRAME - 1)),
      .dec_i      (shifting),
      .zero_o     (cnt_zero)
   );

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer against a frame-level bit model.
// Honours SERIALIZER_PARITY_EN the same way as the design.
module tb_bit_serializer;

   localparam int W = 16;
`ifdef SERIALIZER_PARITY_EN
   localparam int FR = W + 1;
`else
   localparam int FR = W;
`endif

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         Load = 1'b0;
   logic [W-1:0] Data = '0;
   logic         Ready, Out, OutValid, Done;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] wq[$];

   bit_serializer #(.WIDTH(W)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Data     (Data),
      .Load     (Load),
      .Ready    (Ready),
      .Out      (Out),
      .OutValid (OutValid),
      .Done     (Done)
   );

   always #5 Clk = ~Clk;

   // Frame bit i: data LSB first, then even parity of the word.
   function automatic logic exp_bit(input logic [W-1:0] w, input int i);
      if (i < W) return w[i];
      return ($countones(w) % 2) == 1;
   endfunction

   // Streams every word in wq; gap=0 chains in the Done cycle.
   // spur: 1 = random loads mid-frame, 2 = Load held with 0 from bit 5.
   task automatic play(input int gap, input int spur,
                       output logic [W-1:0] cap);
      int n;
      logic [3:0] e;
      n = wq.size();
      cap = '0;
      for (int k = 0; k < n; k++) begin
         if (k == 0 || gap > 0) begin
            for (int g = 1; g < gap && k > 0; g++) begin
               @(posedge Clk); #1;
            end
            checks++;
            if (Ready !== 1'b1 || OutValid !== 1'b0) begin
               failures++;
               $display("FAIL idle_before_load k=%0d ready=%b valid=%b want 1 0",
                        k, Ready, OutValid);
            end
            Load = 1'b1;
            Data = wq[k];
            @(posedge Clk); #1;
            Load = 1'b0;
            Data = W'($urandom);
         end
         for (int i = 0; i < FR; i++) begin
            e = {1'b1, exp_bit(wq[k], i), i == FR - 1, i == FR - 1};
            checks++;
            if ({OutValid, Out, Done, Ready} !== e) begin
               failures++;
               $display("FAIL bit k=%0d i=%0d {valid,out,done,ready} got %b want %b",
                        k, i, {OutValid, Out, Done, Ready}, e);
            end
            if (i < W) cap[i] = Out;
            if (i == FR - 1) begin
               if (gap == 0 && k + 1 < n) begin
                  Load = 1'b1;
                  Data = wq[k + 1];
               end
            end else if (spur == 1 && $urandom_range(3) == 0) begin
               Load = 1'b1;
               Data = W'($urandom);
            end else if (spur == 2 && i >= 5) begin
               Load = 1'b1;
               Data = '0;
            end
            @(posedge Clk); #1;
            Load = 1'b0;
         end
      end
      checks++;
      if (OutValid !== 1'b0 || Ready !== 1'b1 || Out !== 1'b0) begin
         failures++;
         $display("FAIL end_idle valid=%b ready=%b out=%b want 0 1 0",
                  OutValid, Ready, Out);
      end
      wq.delete();
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      Load = 1'b1;
      Data = 16'h2E97;
      #13;
      checks++;
      if ({Ready, OutValid, Out, Done} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_state {ready,valid,out,done} got %b want 1000",
                  {Ready, OutValid, Out, Done});
      end
      Load = 1'b0;
      #4;
      Rst = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if ({Ready, OutValid, Out, Done} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_no_capture got %b want 1000",
                  {Ready, OutValid, Out, Done});
      end
   endtask

   task automatic test_single();
      logic [W-1:0] cap;
      wq.push_back(16'h2E97);
      play(1, 0, cap);
      checks++;
      if (cap !== 16'h2E97) begin
         failures++;
         $display("FAIL single_stream got %h want 2e97", cap);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] cap;
      wq.push_back(16'h2E97);
      wq.push_back(16'hFFFF);
      play(0, 0, cap);
      checks++;
      if (cap !== 16'hFFFF) begin
         failures++;
         $display("FAIL b2b_second got %h want ffff", cap);
      end
   endtask

   task automatic test_mid_load();
      logic [W-1:0] cap;
      wq.push_back(16'h2E97);
      play(1, 2, cap);
      checks++;
      if (cap !== 16'h2E97) begin
         failures++;
         $display("FAIL mid_load_frame got %h want 2e97", cap);
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] cap;
      Load = 1'b1;
      Data = 16'h2E97;
      @(posedge Clk); #1;
      Load = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge Clk); #1;
      end
      checks++;
      if ({OutValid, Out} !== 2'b11) begin
         failures++;
         $display("FAIL pre_abort_bit7 {valid,out} got %b want 11",
                  {OutValid, Out});
      end
      #2;
      Rst = 1'b0;
      #1;
      checks++;
      if ({OutValid, Out, Done, Ready} !== 4'b0001) begin
         failures++;
         $display("FAIL async_abort {valid,out,done,ready} got %b want 0001",
                  {OutValid, Out, Done, Ready});
      end
      #3;
      Rst = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if ({OutValid, Out, Ready} !== 3'b001) begin
         failures++;
         $display("FAIL post_abort_idle {valid,out,ready} got %b want 001",
                  {OutValid, Out, Ready});
      end
      wq.push_back(16'h0001);
      play(1, 0, cap);
      checks++;
      if (cap !== 16'h0001) begin
         failures++;
         $display("FAIL after_abort_frame got %h want 0001", cap);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] cap;
      int gap;
      for (int r = 0; r < 12; r++) begin
         gap = int'($urandom_range(3));
         for (int k = 0; k < 3; k++) wq.push_back(W'($urandom));
         wq.push_back(16'h0003);
         play(gap, 1, cap);
         checks++;
         if (cap !== 16'h0003) begin
            failures++;
            $display("FAIL random_last_word r=%0d got %h want 0003", r, cap);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_mid_load();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
